multicycle_controller: RTL and testbench
========================================

Name: multicycle_controller

Overview:
- Sequencing control unit for the multicycle RV32I datapath.
- Issues the 4-bit ALU control code that the datapath ALU consumes, plus all mux selects and write enables.
- Decodes opcode/funct fields, then steps a Moore FSM through fetch/decode/execute/writeback.
- Consumes the ALU status flags and stalls on a single memory-ready handshake.

Parameters:
- OP_W, 7, opcode width.
- STATE_W, 4, FSM state register width.

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
op  in  7  instruction opcode
funct3  in  3  instruction funct3
funct7b5  in  1  instruction bit 30
zero  in  1  ALUResult == 0
alu_lsb  in  1  ALUResult[0]
mem_ready  in  1  memory access completes this cycle
alu_control  out  4  ALU operation: ADD 0000, SUB 0001, XOR 0010, OR 0011, AND 0100, SLL 0101, SRL 0110, SRA 0111, SLT 1000, SLTU 1001
alu_src_a  out  2  select: 00 PC, 01 OldPC, 10 rs1, 11 zero
alu_src_b  out  2  select: 00 rs2, 01 ImmExt, 10 const 4
result_src  out  2  select: 00 ALUOut, 01 read data, 10 ALUResult
imm_src  out  3  immediate type: 000 I, 001 S, 010 B, 011 J, 100 U
adr_src  out  1  memory address: 0 PC, 1 Result
ir_write  out  1  latch instruction and OldPC
pc_write  out  1  load PC from Result
mem_write  out  1  store strobe
reg_write  out  1  register-file write
illegal  out  1  sticky illegal-instruction flag

Behaviour:
- Reset:
  - rst_n low sets state to FETCH (asynchronous) and clears illegal.
  - While rst_n is low, ir_write, pc_write, mem_write and reg_write are forced to 0.
  - Other outputs take their FETCH values.
- Outputs: pure functions of state. alu_control additionally depends on funct3/funct7b5/op; imm_src on op only (000 for unknown opcodes).
- Unlisted outputs are 0 in every state below; alu_control is ADD unless stated.
- FETCH:
  - Drives adr_src=0, a=00, b=10, result_src=10.
  - When mem_ready=1: ir_write=1 and pc_write=1, then go to DECODE.
  - When mem_ready=0: hold in FETCH with both enables at 0.
- DECODE: a=01, b=01 (ALUOut <= OldPC+imm). Next state by opcode:
  - 0000011 and 0100011 -> MEMADR
  - 0110011 -> EXECR
  - 0010011 -> EXECI
  - 1100011 -> BRANCH
  - 1101111 -> JAL
  - 1100111 -> JALR
  - 0110111 -> LUI
  - 0010111 -> ALUWB
  - anything else -> TRAP
- MEMADR: a=10, b=01. Next is MEMREAD for a load, MEMWRITE for a store. Load/store funct3 other than 010 -> TRAP.
- MEMREAD: adr_src=1, result_src=00. Hold until mem_ready, then MEMWB.
- MEMWRITE: adr_src=1, result_src=00. mem_write=1 for every cycle in the state. On mem_ready -> FETCH.
- MEMWB: result_src=01, reg_write=1 -> FETCH.
- EXECR: a=10, b=00, ALU decode -> ALUWB.
- EXECI: a=10, b=01, ALU decode -> ALUWB.
- ALU decode by funct3:
  - 000 ADD; SUB only when R-type and funct7b5=1.
  - 001 SLL, 010 SLT, 011 SLTU, 100 XOR.
  - 101 SRL, or SRA when funct7b5=1 (both R and I).
  - 110 OR, 111 AND.
- ALUWB: result_src=00, reg_write=1 -> FETCH.
- BRANCH: a=10, b=00, result_src=00. Next state is FETCH.
  - funct3 000 beq: SUB, pc_write=zero.
  - 001 bne: SUB, pc_write=!zero.
  - 100 blt: SLT, pc_write=alu_lsb.
  - 101 bge: SLT, pc_write=!alu_lsb.
  - 110 bltu: SLTU, pc_write=alu_lsb.
  - 111 bgeu: SLTU, pc_write=!alu_lsb.
  - 010/011 -> TRAP, no pc_write.
- JAL: a=01, b=10, result_src=00, pc_write=1 -> ALUWB.
- JALR: a=10, b=01, result_src=10, pc_write=1 -> LINK.
- LINK: a=01, b=10, result_src=10, reg_write=1 -> FETCH.
- LUI: a=11, b=01 -> ALUWB.
- TRAP: illegal=1, all enables 0. Absorbing state; only reset leaves it.
- Latency with mem_ready held 1:
  - branch 3 cycles, auipc 3.
  - R-type 4, I-ALU 4, sw 4, jal 4, jalr 4, lui 4.
  - lw 5.
- Each cycle of mem_ready=0 in FETCH/MEMREAD/MEMWRITE adds one cycle.
- Reset mid-instruction: the next rising clock after rst_n deasserts is in FETCH. No partial writeback occurs.

Decomposition:
- Shared package rv_ctrl_pkg holds:
  - ALU control code constants, named as above.
  - Opcode constants.
  - State encoding.
  - imm_src encoding.
  - mux-select encodings.
- Sub-module alu_decoder: combinational; op, funct3, funct7b5 and state class in, alu_control and branch-illegal out. The FSM stays in the top module.

Test Plan:
- add (op 0110011, f3 000, f7b5 0), mem_ready=1 -> states FETCH,DECODE,EXECR,ALUWB; alu_control 0000 in EXECR; reg_write=1 only in cycle 4.
- sub, then srai (0010011, f3 101, f7b5 1) -> alu_control 0001 and 0111 respectively; addi with f7b5=1 -> 0000.
- lw with mem_ready low 3 cycles in MEMREAD -> 8 cycles total, adr_src=1 throughout the stall, reg_write in MEMWB only; sw -> mem_write=1 in MEMWRITE only.
- bne with zero=0 -> pc_write=1 in BRANCH; bge with alu_lsb=1 -> pc_write=0, alu_control 1000.
- jalr -> pc_write in JALR (result_src 10), reg_write in LINK with a=01, b=10; jal -> pc_write in JAL with result_src 00.
- op 1111111 -> TRAP after DECODE, illegal=1 and no enables for 10 cycles. rst_n pulsed low asynchronously mid-cycle -> illegal=0 and enables 0 immediately; FETCH resumes.

Source files
------------

// File: rtl/rv_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I control unit: ALU codes, opcodes,
// FSM states, immediate types and datapath mux selects.
package rv_ctrl_pkg;

  localparam int unsigned OP_W    = 7;
  localparam int unsigned STATE_W = 4;
  localparam int unsigned ALU_W   = 4;

  typedef enum logic [ALU_W-1:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b0001,
    ALU_XOR  = 4'b0010,
    ALU_OR   = 4'b0011,
    ALU_AND  = 4'b0100,
    ALU_SLL  = 4'b0101,
    ALU_SRL  = 4'b0110,
    ALU_SRA  = 4'b0111,
    ALU_SLT  = 4'b1000,
    ALU_SLTU = 4'b1001
  } alu_op_e;

  localparam logic [OP_W-1:0] OP_LOAD   = 7'b0000011;
  localparam logic [OP_W-1:0] OP_STORE  = 7'b0100011;
  localparam logic [OP_W-1:0] OP_R      = 7'b0110011;
  localparam logic [OP_W-1:0] OP_I      = 7'b0010011;
  localparam logic [OP_W-1:0] OP_BRANCH = 7'b1100011;
  localparam logic [OP_W-1:0] OP_JAL    = 7'b1101111;
  localparam logic [OP_W-1:0] OP_JALR   = 7'b1100111;
  localparam logic [OP_W-1:0] OP_LUI    = 7'b0110111;
  localparam logic [OP_W-1:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWRITE = 4'd4,
    S_MEMWB    = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_JALR     = 4'd11,
    S_LINK     = 4'd12,
    S_LUI      = 4'd13,
    S_TRAP     = 4'd14
  } state_e;

  typedef enum logic [2:0] {
    IMM_I = 3'b000,
    IMM_S = 3'b001,
    IMM_B = 3'b010,
    IMM_J = 3'b011,
    IMM_U = 3'b100
  } imm_e;

  typedef enum logic [1:0] {
    SRCA_PC    = 2'b00,
    SRCA_OLDPC = 2'b01,
    SRCA_RS1   = 2'b10,
    SRCA_ZERO  = 2'b11
  } srca_e;

  typedef enum logic [1:0] {
    SRCB_RS2  = 2'b00,
    SRCB_IMM  = 2'b01,
    SRCB_FOUR = 2'b10
  } srcb_e;

  typedef enum logic [1:0] {
    RES_ALUOUT    = 2'b00,
    RES_RDATA     = 2'b01,
    RES_ALURESULT = 2'b10
  } res_e;

  // Which flavour of ALU decode the current state asks for.
  typedef enum logic [1:0] {
    CLS_ADD    = 2'b00,
    CLS_ALU    = 2'b01,
    CLS_BRANCH = 2'b10
  } alu_cls_e;

  // Immediate format selected by opcode alone; unknown opcodes fall back to I.
  function automatic logic [2:0] imm_sel(input logic [OP_W-1:0] op);
    logic [2:0] sel;
    case (op)
      OP_STORE:          sel = IMM_S;
      OP_BRANCH:         sel = IMM_B;
      OP_JAL:            sel = IMM_J;
      OP_LUI, OP_AUIPC:  sel = IMM_U;
      default:           sel = IMM_I;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU operation decode.
//   op, funct3, funct7b5 : instruction fields
//   cls                  : decode flavour from the FSM (add / alu / branch)
//   alu_control          : 4-bit ALU operation code
//   branch_illegal       : branch funct3 has no defined comparison
module alu_decoder
  import rv_ctrl_pkg::*;
(
  input  logic [OP_W-1:0]  op,
  input  logic [2:0]       funct3,
  input  logic             funct7b5,
  input  logic [1:0]       cls,
  output logic [ALU_W-1:0] alu_control,
  output logic             branch_illegal
);

  always_comb begin
    alu_control    = ALU_ADD;
    branch_illegal = 1'b0;
    if (cls == CLS_ALU) begin
      case (funct3)
        // Immediate forms carry imm[10] in bit 30, so SUB only for R-type.
        3'b000:  alu_control = (op == OP_R && funct7b5) ? ALU_SUB : ALU_ADD;
        3'b001:  alu_control = ALU_SLL;
        3'b010:  alu_control = ALU_SLT;
        3'b011:  alu_control = ALU_SLTU;
        3'b100:  alu_control = ALU_XOR;
        3'b101:  alu_control = funct7b5 ? ALU_SRA : ALU_SRL;
        3'b110:  alu_control = ALU_OR;
        default: alu_control = ALU_AND;
      endcase
    end else if (cls == CLS_BRANCH) begin
      case (funct3)
        3'b000, 3'b001: alu_control = ALU_SUB;
        3'b100, 3'b101: alu_control = ALU_SLT;
        3'b110, 3'b111: alu_control = ALU_SLTU;
        default:        branch_illegal = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/multicycle_controller.sv
// Moore sequencing FSM for the multicycle RV32I datapath.
//   clk, rst_n           : clock, async active-low reset
//   op/funct3/funct7b5   : instruction fields
//   zero, alu_lsb        : ALU status for branch resolution
//   mem_ready            : memory access completes this cycle
//   alu_control          : ALU operation code
//   alu_src_a/b          : ALU operand selects
//   result_src, imm_src  : result mux and immediate format
//   adr_src              : memory address select
//   ir_write, pc_write, mem_write, reg_write : write enables
//   illegal              : sticky illegal-instruction flag (held until reset)
module multicycle_controller
  import rv_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [OP_W-1:0]  op,
  input  logic [2:0]       funct3,
  input  logic             funct7b5,
  input  logic             zero,
  input  logic             alu_lsb,
  input  logic             mem_ready,
  output logic [ALU_W-1:0] alu_control,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       result_src,
  output logic [2:0]       imm_src,
  output logic             adr_src,
  output logic             ir_write,
  output logic             pc_write,
  output logic             mem_write,
  output logic             reg_write,
  output logic             illegal
);

  state_e     state_q, state_d;
  logic [1:0] cls;
  logic       branch_illegal;
  logic       ir_en, pc_en, mw_en, rw_en;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  // Decode flavour depends on state only, kept apart from the main block.
  always_comb begin
    cls = CLS_ADD;
    if (state_q == S_EXECR || state_q == S_EXECI) cls = CLS_ALU;
    else if (state_q == S_BRANCH)                 cls = CLS_BRANCH;
  end

  alu_decoder u_alu_decoder (
    .op             (op),
    .funct3         (funct3),
    .funct7b5       (funct7b5),
    .cls            (cls),
    .alu_control    (alu_control),
    .branch_illegal (branch_illegal)
  );

  // Next state and datapath controls.
  always_comb begin
    state_d    = state_q;
    alu_src_a  = SRCA_PC;
    alu_src_b  = SRCB_RS2;
    result_src = RES_ALUOUT;
    adr_src    = 1'b0;
    ir_en      = 1'b0;
    pc_en      = 1'b0;
    mw_en      = 1'b0;
    rw_en      = 1'b0;
    case (state_q)
      S_FETCH: begin
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALURESULT;
        if (mem_ready) begin
          ir_en   = 1'b1;
          pc_en   = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        case (op)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_R:              state_d = S_EXECR;
          OP_I:              state_d = S_EXECI;
          OP_BRANCH:         state_d = S_BRANCH;
          OP_JAL:            state_d = S_JAL;
          OP_JALR:           state_d = S_JALR;
          OP_LUI:            state_d = S_LUI;
          OP_AUIPC:          state_d = S_ALUWB;
          default:           state_d = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        if (funct3 != 3'b010)  state_d = S_TRAP;
        else if (op == OP_LOAD) state_d = S_MEMREAD;
        else                    state_d = S_MEMWRITE;
      end
      S_MEMREAD: begin
        adr_src = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWRITE: begin
        adr_src = 1'b1;
        mw_en   = 1'b1;
        if (mem_ready) state_d = S_FETCH;
      end
      S_MEMWB: begin
        result_src = RES_RDATA;
        rw_en      = 1'b1;
        state_d    = S_FETCH;
      end
      S_EXECR: begin
        alu_src_a = SRCA_RS1;
        state_d   = S_ALUWB;
      end
      S_EXECI: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        rw_en   = 1'b1;
        state_d = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a = SRCA_RS1;
        // funct3[2] picks the less-than flag over zero; funct3[0] inverts.
        pc_en   = !branch_illegal && ((funct3[2] ? alu_lsb : zero) ^ funct3[0]);
        state_d = branch_illegal ? S_TRAP : S_FETCH;
      end
      S_JAL: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_FOUR;
        pc_en     = 1'b1;
        state_d   = S_ALUWB;
      end
      S_JALR: begin
        alu_src_a  = SRCA_RS1;
        alu_src_b  = SRCB_IMM;
        result_src = RES_ALURESULT;
        pc_en      = 1'b1;
        state_d    = S_LINK;
      end
      S_LINK: begin
        alu_src_a  = SRCA_OLDPC;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALURESULT;
        rw_en      = 1'b1;
        state_d    = S_FETCH;
      end
      S_LUI: begin
        alu_src_a = SRCA_ZERO;
        alu_src_b = SRCB_IMM;
        state_d   = S_ALUWB;
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_FETCH;
    endcase
  end

  assign imm_src = imm_sel(op);
  assign illegal = (state_q == S_TRAP);

  // Enables are suppressed for the whole time reset is held.
  assign ir_write  = ir_en & rst_n;
  assign pc_write  = pc_en & rst_n;
  assign mem_write = mw_en & rst_n;
  assign reg_write = rw_en & rst_n;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: per-cycle vector table with a
// scoreboard of expected output records, plus hand-written reset sequences.
module tb_multicycle_controller;

  localparam logic [6:0] L_LOAD  = 7'b0000011;
  localparam logic [6:0] L_STORE = 7'b0100011;
  localparam logic [6:0] L_R     = 7'b0110011;
  localparam logic [6:0] L_I     = 7'b0010011;
  localparam logic [6:0] L_BR    = 7'b1100011;
  localparam logic [6:0] L_JAL   = 7'b1101111;
  localparam logic [6:0] L_JALR  = 7'b1100111;
  localparam logic [6:0] L_LUI   = 7'b0110111;
  localparam logic [6:0] L_AUIPC = 7'b0010111;
  localparam logic [6:0] L_BAD   = 7'b1111111;

  typedef struct packed {
    logic [3:0] alu;
    logic [1:0] a;
    logic [1:0] b;
    logic [1:0] rs;
    logic [2:0] imm;
    logic       adr;
    logic       irw;
    logic       pcw;
    logic       mw;
    logic       rw;
    logic       ill;
  } exp_t;

  typedef struct {
    string      name;
    logic [6:0] op;
    logic [2:0] f3;
    logic       f7;
    logic       z;
    logic       lsb;
    logic       mr;
    exp_t       x;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5, zero, alu_lsb, mem_ready;
  logic [3:0] alu_control;
  logic [1:0] alu_src_a, alu_src_b, result_src;
  logic [2:0] imm_src;
  logic       adr_src, ir_write, pc_write, mem_write, reg_write, illegal;

  int   vectors = 0;
  int   miscompares = 0;
  vec_t tbl[$];
  exp_t sb[$];

  always #5 clk = ~clk;

  multicycle_controller dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .zero(zero), .alu_lsb(alu_lsb), .mem_ready(mem_ready),
    .alu_control(alu_control), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .result_src(result_src), .imm_src(imm_src), .adr_src(adr_src),
    .ir_write(ir_write), .pc_write(pc_write), .mem_write(mem_write),
    .reg_write(reg_write), .illegal(illegal)
  );

  function automatic exp_t e(input logic [3:0] alu, input logic [1:0] a, input logic [1:0] b,
                             input logic [1:0] rs, input logic [2:0] imm, input logic adr,
                             input logic irw, input logic pcw, input logic mw, input logic rw,
                             input logic ill);
    exp_t r;
    r = '{alu, a, b, rs, imm, adr, irw, pcw, mw, rw, ill};
    return r;
  endfunction

  function automatic exp_t fetch(input logic [2:0] imm, input logic mr);
    return e(4'd0, 2'd0, 2'd2, 2'd2, imm, 1'b0, mr, mr, 1'b0, 1'b0, 1'b0);
  endfunction

  function automatic exp_t decode(input logic [2:0] imm);
    return e(4'd0, 2'd1, 2'd1, 2'd0, imm, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endfunction

  function automatic exp_t aluwb(input logic [2:0] imm);
    return e(4'd0, 2'd0, 2'd0, 2'd0, imm, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
  endfunction

  task automatic v(input string n, input logic [6:0] o, input logic [2:0] f3, input logic f7,
                   input logic z, input logic l, input logic mr, input exp_t x);
    vec_t r;
    r = '{n, o, f3, f7, z, l, mr, x};
    tbl.push_back(r);
  endtask

  // Pop the oldest expectation and compare against the live outputs.
  task automatic compare_pop(input string n);
    exp_t want, got;
    got = '{alu_control, alu_src_a, alu_src_b, result_src, imm_src, adr_src,
            ir_write, pc_write, mem_write, reg_write, illegal};
    vectors++;
    if (sb.size() == 0) begin
      miscompares++;
      $display("FAIL %s: scoreboard empty, got %h", n, got);
      return;
    end
    want = sb.pop_front();
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got alu=%b a=%b b=%b rs=%b imm=%b adr=%b ir=%b pc=%b mw=%b rw=%b ill=%b, want alu=%b a=%b b=%b rs=%b imm=%b adr=%b ir=%b pc=%b mw=%b rw=%b ill=%b",
               n, got.alu, got.a, got.b, got.rs, got.imm, got.adr, got.irw, got.pcw, got.mw,
               got.rw, got.ill, want.alu, want.a, want.b, want.rs, want.imm, want.adr,
               want.irw, want.pcw, want.mw, want.rw, want.ill);
    end
  endtask

  task automatic check_now(input string n, input exp_t x);
    sb.push_back(x);
    compare_pop(n);
  endtask

  // One clock cycle: drive after the rising edge, check on the falling edge.
  task automatic apply(input vec_t t);
    @(posedge clk);
    #1;
    op = t.op; funct3 = t.f3; funct7b5 = t.f7;
    zero = t.z; alu_lsb = t.lsb; mem_ready = t.mr;
    sb.push_back(t.x);
    @(negedge clk);
    compare_pop(t.name);
  endtask

  initial begin
    rst_n = 1'b0; op = 7'd0; funct3 = 3'd0; funct7b5 = 1'b0;
    zero = 1'b0; alu_lsb = 1'b0; mem_ready = 1'b1;

    // Reset state: FETCH selects with enables forced low despite mem_ready.
    #2 check_now("reset", e(4'd0, 2'd0, 2'd2, 2'd2, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    repeat (2) @(posedge clk);
    #1 check_now("reset.hold", e(4'd0, 2'd0, 2'd2, 2'd2, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    mem_ready = 1'b0;
    @(negedge clk) rst_n = 1'b1;

    v("stall.F", L_R, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, fetch(3'd0, 1'b0));
    v("add.F",  L_R, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, fetch(3'd0, 1'b1));
    v("add.D",  L_R, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, decode(3'd0));
    v("add.X",  L_R, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, e(4'd0, 2'd2, 2'd0, 2'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    v("add.WB", L_R, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, aluwb(3'd0));
    v("sub.F",  L_R, 3'd0, 1'b1, 1'b0, 1'b0, 1'b1, fetch(3'd0, 1'b1));
    v("sub.D",  L_R, 3'd0, 1'b1, 1'b0, 1'b0, 1'b1, decode(3'd0));
    v("sub.X",  L_R, 3'd0, 1'b1, 1'b0, 1'b0, 1'b1, e(4'd1, 2'd2, 2'd0, 2'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    v("sub.WB", L_R, 3'd0, 1'b1, 1'b0, 1'b0, 1'b1, aluwb(3'd0));
    v("srai.F", L_I, 3'd5, 1'b1, 1'b0, 1'b0, 1'b1, fetch(3'd0, 1'b1));
    v("srai.D", L_I, 3'd5, 1'b1, 1'b0, 1'b0, 1'b1, decode(3'd0));
    v("srai.X", L_I, 3'd5, 1'b1, 1'b0, 1'b0, 1'b1, e(4'd7, 2'd2, 2'd1, 2'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    v("srai.WB", L_I, 3'd5, 1'b1, 1'b0, 1'b0, 1'b1, aluwb(3'd0));
    v("addi.F", L_I, 3'd0, 1'b1, 1'b0, 1'b0, 1'b1, fetch(3'd0, 1'b1));
    v("addi.D", L_I, 3'd0, 1'b1, 1'b0, 1'b0, 1'b1, decode(3'd0));
    v("addi.X", L_I, 3'd0, 1'b1, 1'b0, 1'b0, 1'b1, e(4'd0, 2'd2, 2'd1, 2'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    v("addi.WB", L_I, 3'd0, 1'b1, 1'b0, 1'b0, 1'b1, aluwb(3'd0));
    v("and.F",  L_R, 3'd7, 1'b0, 1'b0, 1'b0, 1'b1, fetch(3'd0, 1'b1));
    v("and.D",  L_R, 3'd7, 1'b0, 1'b0, 1'b0, 1'b1, decode(3'd0));
    v("and.X",  L_R, 3'd7, 1'b0, 1'b0, 1'b0, 1'b1, e(4'd4, 2'd2, 2'd0, 2'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    v("and.WB", L_R, 3'd7, 1'b0, 1'b0, 1'b0, 1'b1, aluwb(3'd0));
    // lw with a three-cycle read stall: 8 cycles in total.
    v("lw.F",   L_LOAD, 3'd2, 1'b0, 1'b0, 1'b0, 1'b1, fetch(3'd0, 1'b1));
    v("lw.D",   L_LOAD, 3'd2, 1'b0, 1'b0, 1'b0, 1'b1, decode(3'd0));
    v("lw.A",   L_LOAD, 3'd2, 1'b0, 1'b0, 1'b0, 1'b1, e(4'd0, 2'd2, 2'd1, 2'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    for (int i = 0; i < 3; i++)
      v("lw.stall", L_LOAD, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, e(4'd0, 2'd0, 2'd0, 2'd0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    v("lw.R",   L_LOAD, 3'd2, 1'b0, 1'b0, 1'b0, 1'b1, e(4'd0, 2'd0, 2'd0, 2'd0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    v("lw.WB",  L_LOAD, 3'd2, 1'b0, 1'b0, 1'b0, 1'b1, e(4'd0, 2'd0, 2'd0, 2'd1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
    v("sw.F",   L_STORE, 3'd2, 1'b0, 1'b0, 1'b0, 1'b1, fetch(3'd1, 1'b1));
    v("sw.D",   L_STORE, 3'd2, 1'b0, 1'b0, 1'b0, 1'b1, decode(3'd1));
    v("sw.A",   L_STORE, 3'd2, 1'b0, 1'b0, 1'b0, 1'b1, e(4'd0, 2'd2, 2'd1, 2'd0, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    v("sw.stall", L_STORE, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, e(4'd0, 2'd0, 2'd0, 2'd0, 3'd1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
    v("sw.W",   L_STORE, 3'd2, 1'b0, 1'b0, 1'b0, 1'b1, e(4'd0, 2'd0, 2'd0, 2'd0, 3'd1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
    v("bne.F",  L_BR, 3'd1, 1'b0, 1'b0, 1'b0, 1'b1, fetch(3'd2, 1'b1));
    v("bne.D",  L_BR, 3'd1, 1'b0, 1'b0, 1'b0, 1'b1, decode(3'd2));
    v("bne.B",  L_BR, 3'd1, 1'b0, 1'b0, 1'b0, 1'b1, e(4'd1, 2'd2, 2'd0, 2'd0, 3'd2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
    v("beq.F",  L_BR, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, fetch(3'd2, 1'b1));
    v("beq.D",  L_BR, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, decode(3'd2));
    v("beq.B",  L_BR, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, e(4'd1, 2'd2, 2'd0, 2'd0, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    v("bge.F",  L_BR, 3'd5, 1'b0, 1'b0, 1'b1, 1'b1, fetch(3'd2, 1'b1));
    v("bge.D",  L_BR, 3'd5, 1'b0, 1'b0, 1'b1, 1'b1, decode(3'd2));
    v("bge.B",  L_BR, 3'd5, 1'b0, 1'b0, 1'b1, 1'b1, e(4'd8, 2'd2, 2'd0, 2'd0, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    v("bltu.F", L_BR, 3'd6, 1'b0, 1'b0, 1'b1, 1'b1, fetch(3'd2, 1'b1));
    v("bltu.D", L_BR, 3'd6, 1'b0, 1'b0, 1'b1, 1'b1, decode(3'd2));
    v("bltu.B", L_BR, 3'd6, 1'b0, 1'b0, 1'b1, 1'b1, e(4'd9, 2'd2, 2'd0, 2'd0, 3'd2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
    v("jalr.F", L_JALR, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, fetch(3'd0, 1'b1));
    v("jalr.D", L_JALR, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, decode(3'd0));
    v("jalr.J", L_JALR, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, e(4'd0, 2'd2, 2'd1, 2'd2, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
    v("jalr.L", L_JALR, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, e(4'd0, 2'd1, 2'd2, 2'd2, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
    v("jal.F",  L_JAL, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, fetch(3'd3, 1'b1));
    v("jal.D",  L_JAL, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, decode(3'd3));
    v("jal.J",  L_JAL, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, e(4'd0, 2'd1, 2'd2, 2'd0, 3'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
    v("jal.WB", L_JAL, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, aluwb(3'd3));
    v("lui.F",  L_LUI, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, fetch(3'd4, 1'b1));
    v("lui.D",  L_LUI, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, decode(3'd4));
    v("lui.U",  L_LUI, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, e(4'd0, 2'd3, 2'd1, 2'd0, 3'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    v("lui.WB", L_LUI, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, aluwb(3'd4));
    v("auipc.F", L_AUIPC, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, fetch(3'd4, 1'b1));
    v("auipc.D", L_AUIPC, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, decode(3'd4));
    v("auipc.WB", L_AUIPC, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, aluwb(3'd4));
    v("bad.F",  L_BAD, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, fetch(3'd0, 1'b1));
    v("bad.D",  L_BAD, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, decode(3'd0));
    for (int i = 0; i < 10; i++)
      v("trap", L_BAD, 3'd0, 1'b0, 1'b1, 1'b1, 1'b1, e(4'd0, 2'd0, 2'd0, 2'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));

    foreach (tbl[i]) apply(tbl[i]);

    // Asynchronous reset mid-cycle while trapped.
    @(posedge clk);
    #2 mem_ready = 1'b1; rst_n = 1'b0;
    #1 check_now("rst.async", e(4'd0, 2'd0, 2'd2, 2'd2, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    @(negedge clk) mem_ready = 1'b0;
    #2 rst_n = 1'b1;
    tbl.delete();
    v("rst.F",  L_R, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, fetch(3'd0, 1'b1));
    v("rst.D",  L_R, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, decode(3'd0));
    v("rst.X",  L_R, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, e(4'd0, 2'd2, 2'd0, 2'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    v("rst.WB", L_R, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, aluwb(3'd0));
    foreach (tbl[i]) apply(tbl[i]);

    // Reset landing in the middle of ALUWB kills the register write at once.
    #2 rst_n = 1'b0;
    #1 check_now("midrst", e(4'd0, 2'd0, 2'd2, 2'd2, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    mem_ready = 1'b0;
    @(negedge clk) #2 rst_n = 1'b1;

    // Undefined branch funct3 traps without redirecting the PC.
    tbl.delete();
    v("b010.F", L_BR, 3'd2, 1'b0, 1'b1, 1'b1, 1'b1, fetch(3'd2, 1'b1));
    v("b010.D", L_BR, 3'd2, 1'b0, 1'b1, 1'b1, 1'b1, decode(3'd2));
    v("b010.B", L_BR, 3'd2, 1'b0, 1'b1, 1'b1, 1'b1, e(4'd0, 2'd2, 2'd0, 2'd0, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    v("b010.T", L_BR, 3'd2, 1'b0, 1'b1, 1'b1, 1'b1, e(4'd0, 2'd0, 2'd0, 2'd0, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
    foreach (tbl[i]) apply(tbl[i]);

    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard: %0d entries left, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
